// File: rtl/conv_mac_sched_if.sv
// Buffer-read and result-port bundle between the convolution scheduler,
// the ifmap/weight buffers and the ofmap writer.
interface conv_mac_sched_if #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int OFMAP_SIZE    = 4,
    parameter int FILTER_SIZE   = 3,
    parameter int STRIDE        = 1,
    parameter int ACC_WIDTH     = 2 * IP_DATA_WIDTH
);
    localparam int IFMAP_SIZE = (OFMAP_SIZE - 1) * STRIDE + FILTER_SIZE;
    localparam int IA_W       = $clog2(IFMAP_SIZE * IFMAP_SIZE);
    localparam int WA_W       = $clog2(FILTER_SIZE * FILTER_SIZE);
    localparam int RC_W       = $clog2(OFMAP_SIZE);

    logic                     ifmap_rd_en;
    logic [IA_W-1:0]          ifmap_addr;
    logic [IP_DATA_WIDTH-1:0] ifmap_rdata;
    logic [WA_W-1:0]          wt_addr;
    logic [IP_DATA_WIDTH-1:0] wt_rdata;
    logic                     res_valid;
    logic                     res_ready;
    logic [ACC_WIDTH-1:0]     res_data;
    logic [RC_W-1:0]          res_row;
    logic [RC_W-1:0]          res_col;

    modport master (
        output ifmap_rd_en, ifmap_addr, wt_addr, res_valid, res_data, res_row, res_col,
        input  ifmap_rdata, wt_rdata, res_ready
    );

    modport slave (
        input  ifmap_rd_en, ifmap_addr, wt_addr, res_valid, res_data, res_row, res_col,
        output ifmap_rdata, wt_rdata, res_ready
    );
endinterface

// File: rtl/conv_mac_sched.sv
// Time-multiplexed convolution controller: a single shared MAC walks the output
// map row-major, issuing K*K ifmap/weight reads per pixel and emitting each sum.
module conv_mac_sched #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int OFMAP_SIZE    = 4,
    parameter int FILTER_SIZE   = 3,
    parameter int STRIDE        = 1,
    parameter int ACC_WIDTH     = 2 * IP_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    conv_mac_sched_if.master bus
);
    localparam int IFMAP_SIZE = (OFMAP_SIZE - 1) * STRIDE + FILTER_SIZE;
    localparam int IA_W       = $clog2(IFMAP_SIZE * IFMAP_SIZE);
    localparam int WA_W       = $clog2(FILTER_SIZE * FILTER_SIZE);
    localparam int RC_W       = $clog2(OFMAP_SIZE);
    localparam int KW         = $clog2(FILTER_SIZE);
    localparam int PW         = 2 * IP_DATA_WIDTH;
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(OFMAP_SIZE - 1);
    localparam logic [KW-1:0]   K_MAX  = KW'(FILTER_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LAST  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [RC_W-1:0]     r_r, r_c, w_r_nxt, w_c_nxt;
    logic [KW-1:0]       r_kr, r_kc, w_kr_nxt, w_kc_nxt;
    logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt, r_res_data;
    logic [RC_W-1:0]     r_res_row, r_res_col;
    logic [PW-1:0]       w_prod;
    logic                w_acc_clr, w_hs, w_last_pix, w_last_tap;
    logic                r_rd_en, r_rd_vld, r_busy, r_done, r_res_valid;
    logic                w_rd_en_nxt, w_busy_nxt, w_done_nxt, w_valid_nxt;
    logic [IA_W-1:0]     r_ifmap_addr;
    logic [WA_W-1:0]     r_wt_addr;

    function automatic logic [IA_W-1:0] f_ifmap_addr(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c,
                                                     input logic [KW-1:0] kr, input logic [KW-1:0] kc);
        f_ifmap_addr = IA_W'((int'(r) * STRIDE + int'(kr)) * IFMAP_SIZE + int'(c) * STRIDE + int'(kc));
    endfunction

    function automatic logic [WA_W-1:0] f_wt_addr(input logic [KW-1:0] kr, input logic [KW-1:0] kc);
        f_wt_addr = WA_W'(int'(kr) * FILTER_SIZE + int'(kc));
    endfunction

    assign w_hs       = r_res_valid & bus.res_ready;
    assign w_last_pix = (r_r == RC_MAX) && (r_c == RC_MAX);
    assign w_last_tap = (r_kr == K_MAX) && (r_kc == K_MAX);
    assign w_prod     = PW'(bus.ifmap_rdata) * PW'(bus.wt_rdata);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH; else w_state_nxt = S_IDLE;
            S_FETCH: if (w_last_tap) w_state_nxt = S_LAST; else w_state_nxt = S_FETCH;
            S_LAST:  w_state_nxt = S_OUT;
            S_OUT: begin
                if (w_hs) begin
                    if (w_last_pix) w_state_nxt = S_DONE;
                    else            w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they come straight out of flops
    always_comb begin
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_rd_en_nxt = (w_state_nxt == S_FETCH);
        w_valid_nxt = (w_state_nxt == S_OUT);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    // Pixel/tap counter advance and accumulator clear
    always_comb begin
        w_r_nxt   = r_r;
        w_c_nxt   = r_c;
        w_kr_nxt  = r_kr;
        w_kc_nxt  = r_kc;
        w_acc_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_r_nxt   = {RC_W{1'b0}};
                    w_c_nxt   = {RC_W{1'b0}};
                    w_kr_nxt  = {KW{1'b0}};
                    w_kc_nxt  = {KW{1'b0}};
                    w_acc_clr = 1'b1;
                end else begin
                    w_acc_clr = 1'b0;
                end
            end
            S_FETCH: begin
                if (r_kc == K_MAX) begin
                    w_kc_nxt = {KW{1'b0}};
                    if (r_kr == K_MAX) w_kr_nxt = {KW{1'b0}};
                    else               w_kr_nxt = r_kr + KW'(1);
                end else begin
                    w_kc_nxt = r_kc + KW'(1);
                end
            end
            S_OUT: begin
                if (w_hs && !w_last_pix) begin
                    w_kr_nxt  = {KW{1'b0}};
                    w_kc_nxt  = {KW{1'b0}};
                    w_acc_clr = 1'b1;
                    if (r_c == RC_MAX) begin
                        w_c_nxt = {RC_W{1'b0}};
                        w_r_nxt = r_r + RC_W'(1);
                    end else begin
                        w_c_nxt = r_c + RC_W'(1);
                    end
                end else begin
                    w_acc_clr = 1'b0;
                end
            end
            default: w_acc_clr = 1'b0;
        endcase
    end

    // Accumulate only the data returned for a read issued last cycle; wraps silently
    always_comb begin
        if (w_acc_clr)     w_acc_nxt = {ACC_WIDTH{1'b0}};
        else if (r_rd_vld) w_acc_nxt = r_acc + ACC_WIDTH'(w_prod);
        else               w_acc_nxt = r_acc;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r          <= {RC_W{1'b0}};
            r_c          <= {RC_W{1'b0}};
            r_kr         <= {KW{1'b0}};
            r_kc         <= {KW{1'b0}};
            r_acc        <= {ACC_WIDTH{1'b0}};
            r_rd_en      <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_ifmap_addr <= {IA_W{1'b0}};
            r_wt_addr    <= {WA_W{1'b0}};
            r_res_data   <= {ACC_WIDTH{1'b0}};
            r_res_row    <= {RC_W{1'b0}};
            r_res_col    <= {RC_W{1'b0}};
        end else begin
            r_r          <= w_r_nxt;
            r_c          <= w_c_nxt;
            r_kr         <= w_kr_nxt;
            r_kc         <= w_kc_nxt;
            r_acc        <= w_acc_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_rd_vld     <= r_rd_en;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_res_valid  <= w_valid_nxt;
            r_ifmap_addr <= f_ifmap_addr(w_r_nxt, w_c_nxt, w_kr_nxt, w_kc_nxt);
            r_wt_addr    <= f_wt_addr(w_kr_nxt, w_kc_nxt);
            // LAST carries the final product, so the result is latched with it folded in
            if (r_state == S_LAST) begin
                r_res_data <= w_acc_nxt;
                r_res_row  <= r_r;
                r_res_col  <= r_c;
            end else begin
                r_res_data <= r_res_data;
                r_res_row  <= r_res_row;
                r_res_col  <= r_res_col;
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign bus.ifmap_rd_en = r_rd_en;
    assign bus.ifmap_addr  = r_ifmap_addr;
    assign bus.wt_addr     = r_wt_addr;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_row     = r_res_row;
    assign bus.res_col     = r_res_col;
endmodule
